// File: rtl/spi_adc_responder_if.sv
// SPI link and sample bus between an spi_con-style controller and the ADC responder.
// Member names follow the responder's port naming (_in = into responder).
interface spi_adc_responder_if #(
    parameter int DATA_BITS = 10,
    parameter int NUM_CH    = 8
);
    logic                          chip_clk_in;
    logic                          chip_sel_in;
    logic                          chip_data_in;
    logic                          chip_data_out;
    logic [NUM_CH*DATA_BITS-1:0]   samples_in;
    logic                          cmd_valid_out;
    logic [2:0]                    channel_out;
    logic                          single_ended_out;
    logic                          busy_out;
    logic                          xfer_done_out;

    modport master (
        output chip_clk_in, chip_sel_in, chip_data_in, samples_in,
        input  chip_data_out, cmd_valid_out, channel_out, single_ended_out,
               busy_out, xfer_done_out
    );

    modport slave (
        input  chip_clk_in, chip_sel_in, chip_data_in, samples_in,
        output chip_data_out, cmd_valid_out, channel_out, single_ended_out,
               busy_out, xfer_done_out
    );
endinterface

// File: rtl/spi_adc_responder.sv
// MCP3008-style SPI responder: oversamples the controller's SPI lines, decodes
// start/SGL/D2..D0 and shifts back a null bit plus a DATA_BITS sample, MSB first.
module spi_adc_responder #(
    parameter int DATA_BITS = 10,
    parameter int NUM_CH    = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    spi_adc_responder_if.slave  bus
);
    localparam int NW = $clog2(DATA_BITS + 8);
    localparam logic [NW-1:0] N_LAST_CMD = NW'(4);
    localparam logic [NW-1:0] N_FIRST_DATA = NW'(7);
    localparam logic [NW-1:0] N_LAST = NW'(6 + DATA_BITS);

    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, RESP, DONE} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             clk_sync_q, sel_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic [NW-1:0]          n_q, n_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   dout_q, dout_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [2:0]             ch_q, ch_d;
    logic                   sgl_q, sgl_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic clk_s, sel_s, dat_s, clk_rise, clk_fall;
    assign clk_s    = clk_sync_q[1];
    assign sel_s    = sel_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign clk_fall = ~clk_s & clk_prev_q;

    logic [DATA_BITS-1:0] ch_val [NUM_CH];
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_val[k] = bus.samples_in[k*DATA_BITS +: DATA_BITS];
    end

    // The channel addressed by D2..D0 is also the minuend of the differential
    // pair, so single-ended and differential share one mux.
    logic [3:0]           full_cmd;
    logic [DATA_BITS-1:0] minu, subt, result;
    logic [DATA_BITS:0]   diff;
    assign full_cmd = {cmd_q, dat_s};
    assign minu     = ch_val[full_cmd[2:0]];
    assign subt     = ch_val[{full_cmd[2:1], ~full_cmd[0]}];
    assign diff     = {1'b0, minu} - {1'b0, subt};
    assign result   = full_cmd[3] ? minu : (diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0]);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        ch_d        = ch_q;
        sgl_d       = sgl_q;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        done_d      = 1'b0;
        if (state_q == IDLE) begin
            if (!sel_s) state_d = WAIT_START;
        end else if (sel_s) begin
            // Deselect beats any clock edge seen in the same cycle.
            state_d = IDLE;
            dout_d  = 1'b0;
            busy_d  = 1'b0;
            n_d     = '0;
            done_d  = (state_q == DONE);
        end else begin
            case (state_q)
                WAIT_START: begin
                    if (clk_rise && dat_s) begin
                        busy_d  = 1'b1;
                        n_d     = NW'(1);
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (clk_rise) begin
                        n_d   = n_q + 1'b1;
                        cmd_d = full_cmd[2:0];
                        if (n_q == N_LAST_CMD) begin
                            shift_d     = result;
                            ch_d        = full_cmd[2:0];
                            sgl_d       = full_cmd[3];
                            cmd_valid_d = 1'b1;
                            state_d     = RESP;
                        end
                    end
                end
                RESP: begin
                    if (clk_rise) begin
                        n_d = n_q + 1'b1;
                        if (n_q == N_LAST) begin
                            state_d = DONE;
                            dout_d  = 1'b0;
                        end
                    end else if (clk_fall) begin
                        if (n_q >= N_FIRST_DATA && n_q <= N_LAST)
                            {dout_d, shift_d} = {shift_q, 1'b0};
                        else
                            dout_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_sync_q  <= 2'b00;
            sel_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b00;
            clk_prev_q  <= 1'b0;
            state_q     <= IDLE;
            n_q         <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            dout_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            ch_q        <= '0;
            sgl_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.chip_clk_in};
            sel_sync_q  <= {sel_sync_q[0], bus.chip_sel_in};
            dat_sync_q  <= {dat_sync_q[0], bus.chip_data_in};
            clk_prev_q  <= clk_s;
            state_q     <= state_d;
            n_q         <= n_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            cmd_valid_q <= cmd_valid_d;
            ch_q        <= ch_d;
            sgl_q       <= sgl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.chip_data_out    = dout_q;
    assign bus.cmd_valid_out    = cmd_valid_q;
    assign bus.channel_out      = ch_q;
    assign bus.single_ended_out = sgl_q;
    assign bus.busy_out         = busy_q;
    assign bus.xfer_done_out    = done_q;
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- SPI responder that emulates the MCP3008 ADC end of the link that our spi_con controller drives.
- Lets the audio front end (spi_con, 8 kHz trigger, sample capture) be exercised in simulation and on-board loopback without the physical ADC.
- Oversamples the controller's chip clock, select and data lines with the 100 MHz system clock.
- Decodes the start/SGL/D2..D0 command and shifts back a null bit plus a DATA_BITS-wide sample from a parallel sample bus.

Parameters:
- DATA_BITS, 10, width of each returned conversion result (MSB first).
- NUM_CH, 8, number of input channels. Fixed at 8: the command carries a 3-bit channel field.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  reset; asynchronous, active-high.
- chip_clk_in  input  1  SPI clock from the controller; idles low, mode 0.
- chip_sel_in  input  1  chip select from the controller, active low.
- chip_data_in  input  1  controller-to-responder serial data (copi).
- chip_data_out  output  1  responder-to-controller serial data (cipo).
- samples_in  input  NUM_CH*DATA_BITS  channel values; channel k occupies bits [k*DATA_BITS +: DATA_BITS].
- cmd_valid_out  output  1  one-cycle pulse when a full command has been decoded.
- channel_out  output  3  D2..D0 of the last decoded command.
- single_ended_out  output  1  SGL/DIFF bit of the last decoded command.
- busy_out  output  1  high from a detected start bit until the transfer ends or aborts.
- xfer_done_out  output  1  one-cycle pulse after the last data bit (B0) has been driven and chip select rises.

Behaviour:
- Input synchronisation:
  - chip_clk_in, chip_sel_in and chip_data_in each pass through a 2-flop synchroniser.
  - Rise and fall events are taken from the synchronised clock versus its previous value.
  - The controller's clock half-period must be at least 4 clk_in cycles (spi_con uses 25).
- Reset values: chip_data_out=0, cmd_valid_out=0, channel_out=0, single_ended_out=0, busy_out=0, xfer_done_out=0, state IDLE, bit counter 0.
- States:
  - IDLE: leave when synced chip select goes low, to WAIT_START.
  - WAIT_START:
    - Rising edge with copi=0 is ignored (leading zeros are allowed).
    - Rising edge with copi=1 sets busy_out=1, sets bit counter n=1 and moves to CMD.
  - CMD:
    - Rising edges n=2..5 shift in SGL, D2, D1, D0.
    - On the rising edge that sets n=5: latch the result sample into a DATA_BITS shift register in the same cycle, update channel_out and single_ended_out, pulse cmd_valid_out, go to RESP.
  - RESP:
    - Every rising edge increments n.
    - Each falling edge updates chip_data_out: n=6 drives the null bit 0; n=7..6+DATA_BITS drives B(6+DATA_BITS-n), MSB first; n>6+DATA_BITS drives 0.
    - Falling edges with n≤5 leave chip_data_out at 0.
    - With DATA_BITS=10, a 17-clock spi_con transfer returns the sample in data_out[9:0] and the null bit in data_out[10].
  - DONE: entered when n reaches 7+DATA_BITS. chip_data_out=0 and further clocks are ignored until chip select rises.
- Sample latch, single-ended (SGL=1): result = channel D2..D0.
- Sample latch, differential (SGL=0):
  - Pair p = D2..D1.
  - D0=0: result = CH(2p) − CH(2p+1).
  - D0=1: result = CH(2p+1) − CH(2p).
  - Computed at DATA_BITS+1 width and saturated to 0 when negative (no wrap).
- samples_in is sampled only at the latch cycle; later changes do not affect an in-flight transfer.
- Chip select rising (synced) in any state returns to IDLE within 1 cycle.
  - Clears chip_data_out, busy_out and n.
  - xfer_done_out pulses only if the state was DONE; an abort in WAIT_START, CMD or RESP gives no pulse.
  - channel_out and single_ended_out hold their last values.
- Chip select rising and a clock edge seen in the same cycle: chip select wins.
- rst_in asserted mid-transfer forces all reset values immediately.
  - Once rst_in is released, no clock edge is recognised until chip select is seen low from IDLE.
  - A transfer already in progress when reset releases is therefore picked up at its next rising edge with copi=1, which may be mid-frame.
- Back-to-back transfers (chip select high for at least 4 cycles between them) must each work independently.

Test Plan:
- Single-ended CH7: samples CH7=10'h2B5, command {1,1,111}, 17 clocks at half-period 25 → chip_data_out bits after start: null=0 then 1010110101. Controller data_out[9:0]=10'h2B5; cmd_valid_out pulses once with channel_out=7, single_ended_out=1; xfer_done_out pulses once after chip select rises.
- Differential saturation: CH2=100, CH3=40.
  - Command SGL=0, D=010 → 60.
  - Command SGL=0, D=011 → 0 (saturated, no wrap).
- Leading zeros: three copi=0 clocks before the start bit → response identical to scenario 1, shifted by 3 clocks.
- Abort: chip select raised after the 9th clock. chip_data_out=0 and busy_out=0 within 4 cycles, no xfer_done_out; the next full CH0 transfer returns CH0 correctly.
- Async reset mid-RESP: rst_in pulsed between clocks → all outputs 0 immediately, without waiting for a clk_in edge. The remainder of the interrupted frame produces no cmd_valid_out or xfer_done_out unless a later rising edge has copi=1.
- Sample stability: change CH5 from 10'h3FF to 10'h000 during the data phase of a CH5 read → 10'h3FF is still returned.
